// File: rtl/simplearm_lsu_pkg.sv
// simplearm_lsu_pkg: shared LSU size/state types and alignment check.
package simplearm_lsu_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} lsu_state_t;
  // Reserved size is reported through the same error path as misalignment.
  function automatic logic misaligned(lsu_size_t size, logic [1:0] off);
    return (size == SIZE_RSVD) || (size == SIZE_HALF && off[0]) ||
           (size == SIZE_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane replication and byte enables, load shift and extension.
module lsu_lane_align
  import simplearm_lsu_pkg::*;
(
  input  lsu_size_t   size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};
  always_comb begin
    byte_en_o = size_i == SIZE_BYTE ? 4'b0001 << off_i :
                size_i == SIZE_HALF ? 4'b0011 << {off_i[1], 1'b0} :
                size_i == SIZE_WORD ? 4'b1111 : 4'b0000;
    wdata_o   = size_i == SIZE_BYTE ? {4{wdata_i[7:0]}} :
                size_i == SIZE_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o   = size_i == SIZE_BYTE ? {{24{sign_i & sh[7]}}, sh[7:0]} :
                size_i == SIZE_HALF ? {{16{sign_i & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: LSU request to word-aligned data memory bridge.
// Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_bridge
  import simplearm_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  lsu_state_t        state_q, state_d;
  lsu_size_t         size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;
  logic              busy, bad_req;
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  lsu_lane_align u_align (
    .size_i   (size_q),
    .off_i    (addr_q[1:0]),
    .sign_i   (sgn_q),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .byte_en_o(lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  assign bad_req = misaligned(lsu_size_t'(req_size), req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: if (req_valid) begin
        size_d  = lsu_size_t'(req_size);
        addr_d  = req_addr;
        wdata_d = req_wdata;
        we_d    = req_we;
        sgn_d   = req_signed;
        err_d   = bad_req;
        rdata_d = '0;
        state_d = bad_req ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: if (mem_ready) state_d = we_q ? RESP : CAPTURE;
`ifdef LSU_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      CAPTURE: begin
        rdata_d = lane_rdata;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs read zero while idle and hold steady for the whole access.
  assign busy        = state_q != IDLE;
  assign req_ready   = !busy;
  assign mem_addr    = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata   = busy ? lane_wdata : '0;
  assign mem_byte_en = busy ? lane_be : 4'b0000;
  assign mem_rd_en   = state_q == ISSUE && !we_q;
  assign mem_wr_en   = state_q == ISSUE && we_q;
  assign resp_valid  = state_q == RESP;
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = resp_valid && !err_q ? rdata_q : '0;
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: directed checks of lsu_mem_bridge against a behavioural memory.
module tb_lsu_mem_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_rd_en, mem_wr_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic [31:0] mem [256];
  int          lat_cfg = 0, rd_cnt = 0, wr_cnt = 0, busy = 0, cnt = 0;
  bit          stall = 1'b0;
  logic [7:0]  pend_idx = '0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0, last_addr = '0;
  int          total = 0, bad = 0;

  lsu_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory: ready pulses lat_cfg+1 cycles after the access pulse, data held afterwards.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (busy != 0) begin
      if (cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem[pend_idx];
        busy = 0;
      end else cnt--;
    end
    if (mem_rd_en || mem_wr_en) begin
      rd_cnt += int'(mem_rd_en);
      wr_cnt += int'(mem_wr_en);
      last_be = mem_byte_en;
      last_wdata = mem_wdata;
      last_addr = mem_addr;
      pend_idx = mem_addr[9:2];
      if (mem_wr_en)
        for (int i = 0; i < 4; i++)
          if (mem_byte_en[i]) mem[pend_idx][8*i +: 8] = mem_wdata[8*i +: 8];
      if (!stall) begin
        busy = 1;
        cnt = lat_cfg;
      end
    end
  end

  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic err, output logic [31:0] rd,
                      output logic busy_ready, output logic again);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    busy_ready = req_ready;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    err = resp_err;
    rd = resp_rdata;
    @(posedge clk); #1;
    again = resp_valid;
  endtask

  task automatic test_reset();
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if ({mem_rd_en, mem_wr_en, mem_byte_en} !== 6'b0) begin bad++; $display("FAIL reset_mem_ctl got=%b exp=0", {mem_rd_en, mem_wr_en, mem_byte_en}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_word_store();
    int lat; logic err, br, again; logic [31:0] rd; int w0;
    mem[8'h40] = 32'h0;
    w0 = wr_cnt;
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, err, rd, br, again);
    total++; if (last_be !== 4'b1111) begin bad++; $display("FAIL wst_be got=%b exp=1111", last_be); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wst_pulses got=%0d exp=1", wr_cnt - w0); end
    total++; if ({err, rd} !== 33'h0) begin bad++; $display("FAIL wst_resp got err=%b rd=%h exp 0/0", err, rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL wst_latency got=%0d exp=3", lat); end
    total++; if (mem[8'h40] !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[8'h40]); end
    total++; if (last_addr !== 32'h100) begin bad++; $display("FAIL wst_addr got=%h exp=100", last_addr); end
    total++; if (br !== 1'b0) begin bad++; $display("FAIL wst_busy_ready got=%b exp=0", br); end
    total++; if (again !== 1'b0) begin bad++; $display("FAIL wst_resp_one_cycle got=%b exp=0", again); end
  endtask

  task automatic test_byte_load_signed();
    int lat; logic err, br, again; logic [31:0] rd;
    mem[8'h40] = 32'h80FF_0000;
    xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, err, rd, br, again);
    total++; if (last_be !== 4'b1000) begin bad++; $display("FAIL bld_be got=%b exp=1000", last_be); end
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL bld_rdata got=%h exp=ffffff80", rd); end
    total++; if (lat !== 4) begin bad++; $display("FAIL bld_latency got=%0d exp=4", lat); end
    total++; if (last_addr !== 32'h100) begin bad++; $display("FAIL bld_addr got=%h exp=100", last_addr); end
  endtask

  task automatic test_half_load_unsigned();
    int lat; logic err, br, again; logic [31:0] rd;
    mem[8'h40] = 32'h8001_1234;
    xact(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, err, rd, br, again);
    total++; if (last_be !== 4'b1100) begin bad++; $display("FAIL hld_be got=%b exp=1100", last_be); end
    total++; if (rd !== 32'h0000_8001) begin bad++; $display("FAIL hld_rdata got=%h exp=00008001", rd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL hld_err got=%b exp=0", err); end
  endtask

  task automatic test_misaligned();
    int lat; logic err, br, again; logic [31:0] rd; int r0, w0;
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h101, 32'h103, 32'h100};
    for (int i = 0; i < 3; i++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      xact(i[0], sz[i], 1'b0, ad[i], 32'h1234_5678, lat, err, rd, br, again);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err[%0d] got=%b exp=1", i, err); end
      total++; if (lat !== 1) begin bad++; $display("FAIL mis_latency[%0d] got=%0d exp=1", i, lat); end
      total++; if (rd_cnt + wr_cnt - r0 - w0 !== 0) begin bad++; $display("FAIL mis_pulses[%0d] got=%0d exp=0", i, rd_cnt + wr_cnt - r0 - w0); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_rdata[%0d] got=%h exp=0", i, rd); end
    end
  endtask

  task automatic test_byte_store();
    int lat; logic err, br, again; logic [31:0] rd;
    mem[8'h40] = 32'h1122_3344;
    xact(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF5A, lat, err, rd, br, again);
    total++; if (last_wdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL bst_wdata got=%h exp=5a5a5a5a", last_wdata); end
    total++; if (last_be !== 4'b0010) begin bad++; $display("FAIL bst_be got=%b exp=0010", last_be); end
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, err, rd, br, again);
    total++; if (rd !== 32'h1122_5A44) begin bad++; $display("FAIL bst_reload got=%h exp=11225a44", rd); end
    xact(1'b1, 2'b01, 1'b0, 32'h102, 32'hABCD_BEEF, lat, err, rd, br, again);
    total++; if (last_wdata !== 32'hBEEFBEEF || last_be !== 4'b1100) begin bad++; $display("FAIL hst_lanes got=%h/%b exp=beefbeef/1100", last_wdata, last_be); end
  endtask

  task automatic test_slow_memory();
    int lat; logic err, br, again; logic [31:0] rd;
    lat_cfg = 3;
    mem[8'h41] = 32'hCAFE_F00D;
    xact(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, lat, err, rd, br, again);
    total++; if (lat !== 7 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL slow_word got lat=%0d rd=%h exp 7/cafef00d", lat, rd); end
    xact(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, lat, err, rd, br, again);
    total++; if (rd !== 32'hFFFF_CAFE) begin bad++; $display("FAIL slow_half_signed got=%h exp=ffffcafe", rd); end
    xact(1'b1, 2'b10, 1'b0, 32'h108, 32'h0BAD_F00D, lat, err, rd, br, again);
    total++; if (lat !== 6) begin bad++; $display("FAIL slow_store_latency got=%0d exp=6", lat); end
    lat_cfg = 0;
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic err, br, again; logic [31:0] rd;
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b exp=0", req_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmw_idle got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
    @(negedge clk) rst_n = 1'b1;
    stall = 1'b0;
    mem[8'h42] = 32'h7654_3210;
    xact(1'b0, 2'b00, 1'b0, 32'h10A, 32'h0, lat, err, rd, br, again);
    total++; if (rd !== 32'h0000_0054 || err !== 1'b0) begin bad++; $display("FAIL rmw_after got=%h err=%b exp=00000054/0", rd, err); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic err, br, again; logic [31:0] rd;
    stall = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, err, rd, br, again);
    total++; if (err !== 1'b1 || lat !== 18) begin bad++; $display("FAIL timeout got err=%b lat=%0d exp 1/18", err, lat); end
    stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_word_store();
    test_byte_load_signed();
    test_half_load_unsigned();
    test_misaligned();
    test_byte_store();
    test_slow_memory();
    test_reset_mid_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
